// File: rtl/btn_pulse_array_pkg.sv
// btn_pulse_array_pkg: channel FSM state encodings and counter width helper
package btn_pulse_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } chan_st_t;

    function automatic int clog2w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/btn_chan.sv
// btn_chan: one button channel - 2-flop synchroniser, debounce, press/repeat FSM
module btn_chan
    import btn_pulse_array_pkg::*;
#(
    parameter int DB_CYCLES   = 4,
    parameter int REPEAT_EN   = 1,
    parameter int HOLD_CYCLES = 16,
    parameter int RPT_CYCLES  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic press,
    output logic pulse,
    output logic held
);

    localparam int DW = clog2w(DB_CYCLES);
    localparam int TW = clog2w(HOLD_CYCLES > RPT_CYCLES ? HOLD_CYCLES : RPT_CYCLES);

    logic          s1, s2, pulse_nx;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] tmr, tmr_nx;
    chan_st_t      st, st_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            held   <= 1'b0;
            db_cnt <= '0;
            st     <= ST_IDLE;
            tmr    <= '0;
            pulse  <= 1'b0;
        end else begin
            s1 <= press;
            s2 <= s1;
            if (s2 == held)
                db_cnt <= '0;
            else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                held   <= ~held;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
            st    <= st_nx;
            tmr   <= tmr_nx;
            pulse <= pulse_nx;
        end
    end

    // IDLE is only left while held is high and re-entered once it drops,
    // so held seen in IDLE is always a fresh rising edge.
    always_comb begin
        st_nx    = st;
        tmr_nx   = tmr + 1'b1;
        pulse_nx = 1'b0;
        if (st == ST_IDLE) begin
            tmr_nx = '0;
            if (held) begin
                pulse_nx = 1'b1;
                st_nx    = ST_HOLD;
            end
        end else if (!held) begin
            st_nx  = ST_IDLE;
            tmr_nx = '0;
        end else if (st == ST_HOLD && REPEAT_EN != 0 && tmr == TW'(HOLD_CYCLES - 1)) begin
            pulse_nx = 1'b1;
            st_nx    = ST_REPEAT;
            tmr_nx   = '0;
        end else if (st == ST_REPEAT && tmr == TW'(RPT_CYCLES - 1)) begin
            pulse_nx = 1'b1;
            tmr_nx   = '0;
        end
    end

endmodule

// File: rtl/btn_pulse_array.sv
// btn_pulse_array: N_CH independent debounced press-to-pulse channels with auto-repeat
module btn_pulse_array
    import btn_pulse_array_pkg::*;
#(
    parameter int N_CH        = 5,
    parameter int DB_CYCLES   = 4,
    parameter int REPEAT_EN   = 1,
    parameter int HOLD_CYCLES = 16,
    parameter int RPT_CYCLES  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] press,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] held
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .REPEAT_EN  (REPEAT_EN),
            .HOLD_CYCLES(HOLD_CYCLES),
            .RPT_CYCLES (RPT_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .press(press[i]),
            .pulse(pulse[i]),
            .held (held[i])
        );
    end

endmodule

// File: tb/tb_btn_pulse_array.sv
// tb_btn_pulse_array: directed checks of press/glitch/repeat/reset/bounce behaviour
module tb_btn_pulse_array;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  press1 = '0, press2 = '0;
    logic [4:0]  pulse1, held1, pulse2, held2;
    logic [79:0] pm;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    btn_pulse_array dut1 (
        .clk  (clk),
        .rst  (rst),
        .press(press1),
        .pulse(pulse1),
        .held (held1)
    );

    btn_pulse_array #(.REPEAT_EN(0)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .press(press2),
        .pulse(pulse2),
        .held (held2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] rng(input int lo, input int hi);
        logic [79:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Edge k (counted from the latest press change) expects pulse=pm[k], held=hm[k] on channel ch
    task automatic run(input string tag, input bit d2, input int ch, input int first, input int last,
                       input logic [79:0] pmask, input logic [79:0] hmask);
        for (int k = first; k <= last; k++) begin
            tick();
            chk($sformatf("%s.pulse@%0d", tag, k), 32'(d2 ? pulse2[ch] : pulse1[ch]), 32'(pmask[k]));
            chk($sformatf("%s.held@%0d", tag, k), 32'(d2 ? held2[ch] : held1[ch]), 32'(hmask[k]));
            chk($sformatf("%s.others@%0d", tag, k), 32'((d2 ? pulse2 : pulse1) & ~(5'b1 << ch)), 32'd0);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset.pulse1", 32'(pulse1), 32'd0);
        chk("reset.held1", 32'(held1), 32'd0);
        chk("reset.pulse2", 32'(pulse2), 32'd0);
        chk("reset.held2", 32'(held2), 32'd0);
        rst = 1'b0;
        tick();

        press2[0] = 1'b1;
        run("clean", 1, 0, 1, 40, rng(7, 7), rng(6, 40));

        press2[0] = 1'b0;
        run("bounce", 1, 0, 1, 2, '0, rng(1, 13));
        press2[0] = 1'b1;
        run("bounce", 1, 0, 3, 4, '0, rng(1, 13));
        press2[0] = 1'b0;
        run("bounce", 1, 0, 5, 6, '0, rng(1, 13));
        press2[0] = 1'b1;
        run("bounce", 1, 0, 7, 8, '0, rng(1, 13));
        press2[0] = 1'b0;
        run("bounce", 1, 0, 9, 20, '0, rng(1, 13));

        press1[1] = 1'b1;
        run("glitch3", 0, 1, 1, 3, '0, '0);
        press1[1] = 1'b0;
        run("glitch3", 0, 1, 4, 12, '0, '0);
        press1[1] = 1'b1;
        run("glitch1", 0, 1, 1, 1, '0, '0);
        press1[1] = 1'b0;
        run("glitch1", 0, 1, 2, 10, '0, '0);

        pm = rng(7, 7);
        for (int k = 23; k <= 63; k += 8) pm |= rng(k, k);
        press1[2] = 1'b1;
        run("repeat", 0, 2, 1, 60, pm, rng(6, 65));
        press1[2] = 1'b0;
        run("repeat", 0, 2, 61, 75, pm, rng(6, 65));

        press1 = 5'b10001;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) press1[3] = 1'b1;
            tick();
            chk($sformatf("simul.pulse@%0d", k), 32'(pulse1),
                k == 7 ? 32'h11 : k == 9 ? 32'h08 : 32'h00);
            if (k == 6) chk("simul.held@6", 32'(held1), 32'h11);
            if (k == 8) chk("simul.held@8", 32'(held1), 32'h19);
        end
        press1 = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("simul_rel.pulse@%0d", k), 32'(pulse1), 32'd0);
        end
        chk("simul_rel.held", 32'(held1), 32'd0);

        press1[1] = 1'b1;
        run("prerst", 0, 1, 1, 25, rng(7, 7) | rng(23, 23), rng(6, 25));
        rst = 1'b1;
        tick();
        chk("midrst.pulse", 32'(pulse1), 32'd0);
        chk("midrst.held", 32'(held1), 32'd0);
        rst = 1'b0;
        run("postrst", 0, 1, 1, 12, rng(7, 7), rng(6, 12));
        press1[1] = 1'b0;
        run("postrst_rel", 0, 1, 1, 10, '0, rng(1, 5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
